// File: rtl/mips_regfile_sb_pkg.sv
// Shared constants for the mips_32_pipeline family: regfile defaults,
// the hardwired zero register and the opcode encodings used by the pipeline.
package mips32_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_NUM_REGS = 32;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_SLT  = 6'b000100;
    localparam logic [5:0] OP_MUL  = 6'b000101;
    localparam logic [5:0] OP_HLT  = 6'b111111;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b001001;
    localparam logic [5:0] OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011;
    localparam logic [5:0] OP_SLTI = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ = 6'b001110;

endpackage

// File: rtl/mips_regfile_sb_if.sv
// Operand-read / issue / writeback bus between the ID/WB stages (master)
// and the scoreboarded register file (slave).
interface mips_regfile_sb_if
    import mips32_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     issue_valid;
    logic [ADDR_W-1:0]        issue_dst;
    logic                     issue_ready;
    logic                     wb_valid;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic [ADDR_W:0]          pending_cnt;
    logic                     wb_err;

    modport master (
        output rd_addr, issue_valid, issue_dst, wb_valid, wb_addr, wb_data,
        input  rd_data, rd_busy, issue_ready, pending_cnt, wb_err
    );

    modport slave (
        input  rd_addr, issue_valid, issue_dst, wb_valid, wb_addr, wb_data,
        output rd_data, rd_busy, issue_ready, pending_cnt, wb_err
    );
endinterface

// File: rtl/mips_sb_bits.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback (a same-cycle issue wins), plus popcount and sticky error flag.
module mips_sb_bits
    import mips32_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                issue_valid_i,
    input  logic [ADDR_W-1:0]   issue_dst_i,
    input  logic                wb_valid_i,
    input  logic [ADDR_W-1:0]   wb_addr_i,
    output logic [NUM_REGS-1:0] pending_o,
    output logic                issue_ready_o,
    output logic [ADDR_W:0]     pending_cnt_o,
    output logic                wb_err_o
);
    localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NUM_REGS);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                wb_hit_issue, set_en, clr_en, err_now;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < LIM;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic pend_at(input logic [NUM_REGS-1:0] p, input logic [ADDR_W-1:0] a);
        return in_range(a) && p[a];
    endfunction

    always_comb begin
        wb_hit_issue  = wb_valid_i && (wb_addr_i == issue_dst_i);
        issue_ready_o = !pend_at(pending_q, issue_dst_i) || wb_hit_issue;
        set_en = issue_valid_i && issue_ready_o && in_range(issue_dst_i) && !is_zero(issue_dst_i);
        clr_en = wb_valid_i && in_range(wb_addr_i) && !is_zero(wb_addr_i);

        pending_d = pending_q;
        if (clr_en) pending_d[wb_addr_i] = 1'b0;
        if (set_en) pending_d[issue_dst_i] = 1'b1;

        // Counting the next vector keeps the count exact even for stray writebacks.
        cnt_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            cnt_d = cnt_d + (ADDR_W+1)'(pending_d[i]);

        err_now = (wb_valid_i && !in_range(wb_addr_i))
               || (issue_valid_i && !in_range(issue_dst_i))
               || (wb_valid_i && in_range(wb_addr_i) && !pend_at(pending_q, wb_addr_i)
                   && !(issue_valid_i && issue_dst_i == wb_addr_i) && !is_zero(wb_addr_i));
        err_d = err_q || err_now;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign pending_o     = pending_q;
    assign pending_cnt_o = cnt_q;
    assign wb_err_o      = err_q;
endmodule

// File: rtl/mips_regfile_sb.sv
// Register file with write-through bypass and pending-write scoreboard;
// ID reads operands and stalls on rd_busy, issue marks dst, WB clears it.
module mips_regfile_sb
    import mips32_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk1,
    input  logic              rst_n,
    mips_regfile_sb_if.slave  bus
);
    localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]        Reg [NUM_REGS];
    logic [NUM_REGS-1:0]      pending;
    logic                     issue_ready;
    logic [ADDR_W:0]          pending_cnt;
    logic                     wb_err;
    logic                     wb_we;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;
    logic [ADDR_W-1:0]        ra;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < LIM;
    endfunction

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return in_range(a) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    mips_sb_bits #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk1          (clk1),
        .rst_n         (rst_n),
        .issue_valid_i (bus.issue_valid),
        .issue_dst_i   (bus.issue_dst),
        .wb_valid_i    (bus.wb_valid),
        .wb_addr_i     (bus.wb_addr),
        .pending_o     (pending),
        .issue_ready_o (issue_ready),
        .pending_cnt_o (pending_cnt),
        .wb_err_o      (wb_err)
    );

    assign wb_we = bus.wb_valid && writable(bus.wb_addr);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) Reg[i] <= '0;
        end else if (wb_we) begin
            Reg[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
            if (wb_we && bus.wb_addr == ra)
                rd_data_c[i*DATA_W +: DATA_W] = bus.wb_data;
            else if (writable(ra))
                rd_data_c[i*DATA_W +: DATA_W] = Reg[ra];
            rd_busy_c[i] = in_range(ra) && pending[ra] && !(bus.wb_valid && bus.wb_addr == ra);
        end
    end

    assign bus.rd_data     = rd_data_c;
    assign bus.rd_busy     = rd_busy_c;
    assign bus.issue_ready = issue_ready;
    assign bus.pending_cnt = pending_cnt;
    assign bus.wb_err      = wb_err;
endmodule

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
- Parametrised register file with a per-register pending-write scoreboard and write-through bypass, for the mips_32_pipeline family.
- Replaces the bare Reg array. The ID stage reads operands and stalls on pending sources. Issue marks the destination pending; WB clears it.
- Removes the need for dummy OR instructions between dependent ALU ops.
- Single clock domain.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS
- NUM_RD, 2, number of combinational read ports
- ZERO_REG, 1, 1 = register 0 is hardwired to zero

Ports:
- clk1  input  1  sole clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  packed read data, combinational
- rd_busy  output  NUM_RD  1 = source register has an outstanding write (ID must stall)
- issue_valid  input  1  ID issuing an instruction that writes issue_dst
- issue_dst  input  ADDR_W  destination register of the issuing instruction
- issue_ready  output  1  1 = issue_dst may be marked pending this cycle
- wb_valid  input  1  writeback strobe
- wb_addr  input  ADDR_W  writeback register
- wb_data  input  DATA_W  writeback value
- pending_cnt  output  ADDR_W+1  number of registers currently pending
- wb_err  output  1  sticky flag: writeback to a non-pending register, or an out-of-range address

Behaviour:
- Reset (async assert, sync release on clk1):
  - all registers 0, all pending bits 0;
  - pending_cnt 0, wb_err 0;
  - rd_data shows 0; rd_busy 0; issue_ready 1.
- Read port i (combinational, zero latency):
  - if wb_valid and wb_addr == rd_addr[i] and the address is writable, rd_data[i] = wb_data (write-through bypass);
  - otherwise rd_data[i] = Reg[rd_addr[i]].
  - Register 0 reads 0 when ZERO_REG = 1.
  - Address >= NUM_REGS reads 0.
- rd_busy[i] = pending[rd_addr[i]] AND NOT (wb_valid AND wb_addr == rd_addr[i]).
  - A same-cycle writeback releases the dependency; the value arrives via bypass.
- issue_ready = NOT pending[issue_dst] OR (wb_valid AND wb_addr == issue_dst).
  - This is the WAW guard. It is independent of issue_valid.
- Rising edge, writeback:
  - if wb_valid and wb_addr is writable: Reg[wb_addr] <= wb_data, pending[wb_addr] <= 0.
- Rising edge, issue:
  - if issue_valid and issue_ready and issue_dst is writable: pending[issue_dst] <= 1.
  - Issue while issue_ready = 0 is ignored; the caller is required to hold it.
- Simultaneous writeback and issue to the same dst:
  - register takes wb_data;
  - pending ends at 1, because the new issue wins.
- Writeback to register 0 (ZERO_REG = 1): ignored, with no error. Issue to register 0 never sets pending.
- wb_err is set (sticky until reset) when:
  - wb_valid to an address with pending = 0, with no same-cycle issue to it and the address not register 0; or
  - any wb_valid or issue_valid to an address >= NUM_REGS.
  - In both cases the write itself is still performed if the address is in range.
- pending_cnt is registered and equals the popcount of the pending bits after each edge.
  - Updates: +1 on set only, -1 on clear only, 0 on both (same register, or different registers in the same cycle).
- Reset asserted mid-operation: all pending state and data are lost immediately; outputs take reset values while rst_n = 0.
- Direct hierarchical preload of the data array is permitted in benches after reset release; the array is named Reg.

Decomposition:
- Package mips32_pkg holds:
  - DATA_W / ADDR_W / NUM_REGS defaults;
  - REG_ZERO constant;
  - the opcode localparams shared with the pipeline.
- One sub-module, mips_sb_bits: the pending bit vector, issue/clear logic, pending_cnt and wb_err.
- The data array and read muxes stay in the top module.

Test Plan:
- Reset, then read R0..R31 on both ports → all 0; rd_busy = 00; pending_cnt = 0; issue_ready = 1.
- Issue R1, then 3 cycles later wb R1 = 10 → rd_busy for R1 is 1 in the intervening cycles. In the wb cycle rd_busy = 0 and rd_data = 10 via bypass. Next cycle Reg[1] = 10, pending_cnt = 0.
- Program sequence:
  - issue R1, R2, R3; wb R1 = 10, R2 = 20, R3 = 25 one per cycle;
  - then issue R4; wb R4 = 30; then read R4, R3 → 30, 25.
  - pending_cnt sequence 1, 2, 3, 2, 1, 0, 1, 0.
- WAW: R5 pending; issue R5 without wb → issue_ready = 0, pending_cnt unchanged.
  - Same cycle as wb R5 = 55 → issue_ready = 1.
  - After the edge: Reg[5] = 55, pending[5] = 1, rd_busy = 1 on a read of R5.
- R0 handling: issue R0 and wb R0 = 0xDEADBEEF → read R0 = 0, pending_cnt = 0, wb_err = 0.
- Errors: wb R7 with R7 not pending → wb_err = 1 and Reg[7] updated. Assert rst_n = 0 mid-sequence with 3 pending → immediately pending_cnt = 0, wb_err = 0, and all reads 0.
